seg_display_engine: RTL

Parametrised, clocked binary-to-seven-segment engine for the board's HEX display bank. Accepts a binary value on a load strobe, converts it serially with shift-and-add-3 (double dabble, one bit per clock), and presents registered, active-low segment patterns for DIGITS digits. Adds leading-zero blanking, overflow indication and a busy/done handshake. Sits between the datapath and the HEX pins.

---
 rtl/seg_display_engine.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_engine.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_engine
//  Description : Clocked binary-to-seven-segment engine for a bank of HEX
//                displays. A binary value is captured on an accepted load and
//                converted serially with shift-and-add-3 (double dabble), one
//                bit per clock. The result is shown as registered, active-low
//                segment patterns with optional leading-zero blanking and an
//                overflow indication (all dashes).
//  Ports       : clk       - system clock, all state changes on rising edge
//                reset     - synchronous, active-high reset
//                value     - unsigned binary input, sampled on accepted load
//                load      - start request, accepted only while busy is low
//                busy      - conversion in progress
//                done      - one-cycle pulse when segs/overflow update
//                overflow  - last converted value was >= 10^DIGITS
//                segs      - digit i on segs[7i+6:7i], bit 6 = g .. bit 0 = a,
//                            active low (0 = lit)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_engine #(
    parameter int WIDTH    = 20,
    parameter int DIGITS   = 6,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   segs
);

    localparam int c_BCDW = 4 * DIGITS;
    localparam int c_CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNTW-1:0] c_CNT_LAST = c_CNTW'(WIDTH - 1);

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [WIDTH-1:0]      r_bin;
    logic [c_BCDW-1:0]     r_bcd;
    logic                  r_carry;
    logic [c_CNTW-1:0]     r_cnt;
    logic [7*DIGITS-1:0]   r_segs;
    logic                  r_ovf;
    logic                  r_done;

    logic [c_BCDW-1:0]     w_bcd_adj;
    logic [7*DIGITS-1:0]   w_segs_nxt;
    // w_hz[k] : digits k..DIGITS-1 of the finished BCD value are all zero
    logic [DIGITS:1]       w_hz;

    // ------------------------------------------------------------------
    // Segment decoder (gfedcba, active low). Nibbles never exceed 9, so
    // the default arm is unreachable and only keeps the decode total.
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_seg7(input logic [3:0] i_d);
        logic [6:0] v_s;
        case (i_d)
            4'd0:    v_s = 7'b1000000;
            4'd1:    v_s = 7'b1111001;
            4'd2:    v_s = 7'b0100100;
            4'd3:    v_s = 7'b0110000;
            4'd4:    v_s = 7'b0011001;
            4'd5:    v_s = 7'b0010010;
            4'd6:    v_s = 7'b0000010;
            4'd7:    v_s = 7'b1111000;
            4'd8:    v_s = 7'b0000000;
            4'd9:    v_s = 7'b0011000;
            default: v_s = c_SEG_BLANK;
        endcase
        return v_s;
    endfunction

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Add-3 correction: every nibble >= 5 gets +3 before the shift so that
    // doubling it carries correctly into the next decimal digit.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                        ? (r_bcd[4*gi +: 4] + 4'd3)
                                        : r_bcd[4*gi +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Display pattern for the finished conversion. Leading-zero detection
    // runs from the most significant digit downwards; digit 0 is always
    // shown. Overflow overrides everything with dashes.
    // ------------------------------------------------------------------
    assign w_hz[DIGITS] = 1'b1;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            if (gi > 0) begin : g_hz
                assign w_hz[gi] = w_hz[gi+1] & (r_bcd[4*gi +: 4] == 4'd0);
            end

            if (gi == 0) begin : g_lsd
                assign w_segs_nxt[6:0] = r_carry ? c_SEG_DASH
                                                 : f_seg7(r_bcd[3:0]);
            end else begin : g_msd
                assign w_segs_nxt[7*gi +: 7] =
                    r_carry                        ? c_SEG_DASH  :
                    ((BLANK_LZ != 0) && w_hz[gi])  ? c_SEG_BLANK :
                                                     f_seg7(r_bcd[4*gi +: 4]);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath: capture, serial conversion and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin   <= '0;
            r_bcd   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_segs  <= '1;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_bin   <= value;
                        r_bcd   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    // The BCD MSB leaving the register means the value needs
                    // more digits than are available: remember it as overflow.
                    {r_bcd, r_bin} <= {w_bcd_adj[c_BCDW-2:0], r_bin, 1'b0};
                    r_carry        <= r_carry | w_bcd_adj[c_BCDW-1];
                    r_cnt          <= r_cnt + 1'b1;
                end
                S_FINISH: begin
                    r_segs <= w_segs_nxt;
                    r_ovf  <= r_carry;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign overflow = r_ovf;
    assign segs     = r_segs;

endmodule
`default_nettype wire
